dbuf_fifo: RTL and testbench
============================

DBUF_FIFO -- requirements
Module: dbuf_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data width of one entry.
REQ-002 Parameter DEPTH, default 4, number of entries; power of two, >= 2.
REQ-003 Parameter OP_LEN, default `SFR_OP_LEN, width of the SFR operation bus.
REQ-004 i_clk  input  1  clock; single clock domain, all state updates on its rising edge.
REQ-005 i_rst  input  1  reset; synchronous, active-low.
REQ-006 i_byte  input  WIDTH  data to push from the SFR side.
REQ-007 i_op  input  OP_LEN  operation bitmask; bits `OP_DBUF_WR_BYTE (push) and `OP_DBUF_CLR (flush) are decoded.
REQ-008 o_dbuf  output  WIDTH  last value written by the SFR side (legacy DBUF readback).
REQ-009 o_data  output  WIDTH  head entry of the FIFO.
REQ-010 o_valid  output  1  FIFO non-empty; o_data is valid.
REQ-011 i_ready  input  1  consumer accepts head; pop occurs when o_valid && i_ready.
REQ-012 o_full  output  1  count == DEPTH.
REQ-013 o_empty  output  1  count == 0; always equals !o_valid.
REQ-014 o_count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-015 o_ovf  output  1  sticky overflow flag.

Function
REQ-016 An op bit is active when (i_op & bit) is non-zero; several bits may be active in one cycle.
REQ-017 Push: WR active, CLR inactive, and (!o_full or a pop in the same cycle) -> i_byte stored at write pointer, write pointer +1 modulo DEPTH.
REQ-018 Pop: o_valid && i_ready && CLR inactive -> read pointer +1 modulo DEPTH.
REQ-019 Count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop, including when full.
REQ-020 Push latency 1 cycle: a byte pushed into an empty FIFO appears on o_data with o_valid=1 on the following cycle; no same-cycle fall-through.
REQ-021 WR active while full with no same-cycle pop: i_byte dropped, FIFO contents and pointers unchanged, o_ovf set to 1 the next cycle.
REQ-022 o_ovf stays 1 until CLR or reset; further overflows have no additional effect.
REQ-023 o_dbuf loads i_byte on every cycle with WR active and CLR inactive, including dropped (overflow) writes.
REQ-024 CLR has priority: pointers and count go to 0 and o_ovf to 0 the next cycle; a same-cycle WR and pop are both ignored; o_dbuf unchanged.
REQ-025 Pop on empty (i_ready=1, o_valid=0) has no effect.
REQ-026 o_data SHALL be 0 whenever o_empty=1.
REQ-027 o_full, o_empty, o_valid, o_count are derived from registered state only, with no combinational path from i_op, i_byte or i_ready.

Reset
REQ-028 While i_rst=0 at a rising edge: pointers, count, o_ovf and o_dbuf become 0; o_empty=1, o_valid=0, o_full=0, o_data=0 next cycle.
REQ-029 Reset mid-operation discards all stored entries; storage array contents need not be cleared.
REQ-030 Reset overrides CLR, WR and pop in the same cycle.

Structure
REQ-031 `OP_DBUF_WR_BYTE, the new `OP_DBUF_CLR bit and `SFR_OP_LEN live in the shared Defines.v header; no op encodings are local to the module.
REQ-032 Single module with no sub-modules: inline register-array storage, pointers of $clog2(DEPTH) bits, and a separate count register.
REQ-033 With DEPTH=1 semantics not required; an elaboration-time check rejects a DEPTH that is not a power of two or is below 2.

Verification (WIDTH=8, DEPTH=4)
REQ-034 Reset release, WR 0x11, 0x22 with i_ready=0 -> o_count=2, o_data=0x11, o_dbuf=0x22, o_valid=1 one cycle after the second write.
REQ-035 Five writes 0xA0..0xA4, i_ready=0 -> o_full=1 after the fourth; 0xA4 dropped, o_ovf=1, o_dbuf=0xA4; then pop four -> 0xA0..0xA3 in order, o_empty=1.
REQ-036 Full FIFO, WR 0xB5 with i_ready=1 in the same cycle -> head advances, 0xB5 stored last, o_count stays 4, o_ovf unchanged.
REQ-037 Ten push/pop cycles with i_ready=1 continuously -> pointers wrap; data out matches data in order with 1-cycle latency; o_count never exceeds 1.
REQ-038 Three entries stored, o_ovf=1, CLR+WR 0xCC in one cycle -> next cycle o_count=0, o_ovf=0, o_data=0, o_dbuf unchanged (not 0xCC).
REQ-039 i_rst=0 asserted with two entries stored and WR active -> next cycle all outputs 0 except o_empty=1; a subsequent pop attempt has no effect.

Source files
------------

// File: rtl/dbuf_fifo_pkg.sv
// Shared SFR operation definitions (op bus width, DBUF op bitmasks) and FIFO helpers.
// The op macros are global so every block that decodes the SFR op bus sees one encoding.
`ifndef SFR_OP_LEN
`define SFR_OP_LEN 8
`endif
`ifndef OP_DBUF_WR_BYTE
`define OP_DBUF_WR_BYTE 8'h01
`endif
`ifndef OP_DBUF_CLR
`define OP_DBUF_CLR 8'h02
`endif

package dbuf_fifo_pkg;

  localparam int SFR_OP_W = `SFR_OP_LEN;
  localparam logic [SFR_OP_W-1:0] OP_WR_MASK  = SFR_OP_W'(`OP_DBUF_WR_BYTE);
  localparam logic [SFR_OP_W-1:0] OP_CLR_MASK = SFR_OP_W'(`OP_DBUF_CLR);

  function automatic bit is_pow2_ge2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/dbuf_fifo.sv
// SFR-side byte FIFO with legacy DBUF readback: push latency 1 cycle, no fall-through.
// Consumer pops with o_valid && i_ready; writes to a full FIFO without a same-cycle pop are dropped and flag o_ovf.
module dbuf_fifo
  import dbuf_fifo_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int OP_LEN = `SFR_OP_LEN
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [WIDTH-1:0]         i_byte,
  input  logic [OP_LEN-1:0]        i_op,
  output logic [WIDTH-1:0]         o_dbuf,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  generate
    if (!is_pow2_ge2(DEPTH)) begin : g_bad_depth
      $error("dbuf_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic [WIDTH-1:0] r_dbuf;

  logic w_wr;
  logic w_clr;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_ovf_evt;

  assign w_wr      = |(i_op & OP_LEN'(`OP_DBUF_WR_BYTE));
  assign w_clr     = |(i_op & OP_LEN'(`OP_DBUF_CLR));
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = !w_empty && i_ready && !w_clr;
  // A same-cycle pop frees a slot, so a full FIFO can still accept the write.
  assign w_push    = w_wr && !w_clr && (!w_full || w_pop);
  assign w_ovf_evt = w_wr && !w_clr && w_full && !w_pop;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_byte;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else if (w_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_ovf_evt) r_ovf <= 1'b1;
    end
  end

  // DBUF mirrors every accepted SFR write, including ones the FIFO drops.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_dbuf <= '0;
    end else if (w_wr && !w_clr) begin
      r_dbuf <= i_byte;
    end
  end

  assign o_dbuf  = r_dbuf;
  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_valid = !w_empty;
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_count = r_count;
  assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_dbuf_fifo.sv
// Scoreboard bench for dbuf_fifo (WIDTH=8, DEPTH=4): directed ops, expected pops queued by the stimulus.
module tb_dbuf_fifo;
  import dbuf_fifo_pkg::*;

  logic                i_clk = 1'b0;
  logic                i_rst = 1'b0;
  logic [7:0]          i_byte = '0;
  logic [SFR_OP_W-1:0] i_op = '0;
  logic                i_ready = 1'b0;
  logic [7:0]          o_dbuf;
  logic [7:0]          o_data;
  logic                o_valid;
  logic                o_full;
  logic                o_empty;
  logic [2:0]          o_count;
  logic                o_ovf;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q [$];

  dbuf_fifo #(.WIDTH(8), .DEPTH(4), .OP_LEN(SFR_OP_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_byte(i_byte), .i_op(i_op),
    .o_dbuf(o_dbuf), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_full(o_full), .o_empty(o_empty), .o_count(o_count), .o_ovf(o_ovf)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs are stable at the falling edge; a pop will happen at the next rising edge.
  always @(negedge i_clk) begin
    if (i_rst && o_valid && i_ready && !(|(i_op & OP_CLR_MASK))) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h expected no pop", o_data);
      end else begin
        chk("pop_data", {24'h0, o_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic step(input logic wr, input logic clr, input logic [7:0] b, input logic rdy);
    i_op    = (wr ? OP_WR_MASK : '0) | (clr ? OP_CLR_MASK : '0);
    i_byte  = b;
    i_ready = rdy;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    // Reset
    i_rst = 1'b0;
    step(1'b1, 1'b0, 8'h5A, 1'b1);
    chk("rst_count", o_count, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_full",  o_full,  0);
    chk("rst_data",  o_data,  0);
    chk("rst_ovf",   o_ovf,   0);
    chk("rst_dbuf",  o_dbuf,  0);
    i_rst = 1'b1;

    // Two writes, no consumer
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    step(1'b1, 1'b0, 8'h11, 1'b0);
    chk("t1_lat_valid", o_valid, 1);
    chk("t1_lat_data",  o_data,  8'h11);
    step(1'b1, 1'b0, 8'h22, 1'b0);
    chk("t1_count", o_count, 2);
    chk("t1_data",  o_data,  8'h11);
    chk("t1_dbuf",  o_dbuf,  8'h22);
    chk("t1_valid", o_valid, 1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t1_empty", o_empty, 1);

    // Fill, overflow, drain
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hA0 + 8'(i));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0);
    chk("t2_full", o_full, 1);
    chk("t2_ovf_pre", o_ovf, 0);
    step(1'b1, 1'b0, 8'hA4, 1'b0);
    chk("t2_ovf",   o_ovf,   1);
    chk("t2_dbuf",  o_dbuf,  8'hA4);
    chk("t2_count", o_count, 4);
    chk("t2_head",  o_data,  8'hA0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t2_empty", o_empty, 1);
    chk("t2_data0", o_data,  0);
    chk("t2_ovf_sticky", o_ovf, 1);

    // Clear, fill, write while full with a same-cycle pop
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("t3_ovf_clr", o_ovf, 0);
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'hB0 + 8'(i));
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 8'hB0 + 8'(i), 1'b0);
    exp_q.push_back(8'hB5);
    step(1'b1, 1'b0, 8'hB5, 1'b1);
    chk("t3_count", o_count, 4);
    chk("t3_head",  o_data,  8'hB2);
    chk("t3_ovf",   o_ovf,   0);
    chk("t3_full",  o_full,  1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t3_empty", o_empty, 1);

    // Streaming with continuous ready
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(8'h30 + 8'(i));
      step(1'b1, 1'b0, 8'h30 + 8'(i), 1'b1);
      chk("t4_count_le1", {31'h0, (o_count <= 3'd1)}, 1);
      chk("t4_data", o_data, 8'h30 + 8'(i));
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t4_empty", o_empty, 1);

    // Clear with write: three entries held, overflow flagged
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hC0 + 8'(i));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'hC0 + 8'(i), 1'b0);
    step(1'b1, 1'b0, 8'hC4, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t5_pre_count", o_count, 3);
    chk("t5_pre_ovf",   o_ovf,   1);
    step(1'b1, 1'b1, 8'hCC, 1'b1);
    exp_q.delete();
    chk("t5_count", o_count, 0);
    chk("t5_ovf",   o_ovf,   0);
    chk("t5_data",  o_data,  0);
    chk("t5_dbuf",  o_dbuf,  8'hC4);
    chk("t5_empty", o_empty, 1);

    // Reset mid-operation
    exp_q.push_back(8'hD1); exp_q.push_back(8'hD2);
    step(1'b1, 1'b0, 8'hD1, 1'b0);
    step(1'b1, 1'b0, 8'hD2, 1'b0);
    i_rst = 1'b0;
    step(1'b1, 1'b0, 8'hDE, 1'b0);
    exp_q.delete();
    chk("t6_count", o_count, 0);
    chk("t6_empty", o_empty, 1);
    chk("t6_valid", o_valid, 0);
    chk("t6_full",  o_full,  0);
    chk("t6_data",  o_data,  0);
    chk("t6_dbuf",  o_dbuf,  0);
    chk("t6_ovf",   o_ovf,   0);
    i_rst = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t6_pop_count", o_count, 0);
    chk("t6_pop_empty", o_empty, 1);

    chk("sb_leftover", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no end of stimulus, expected finish before 20000");
    $fatal(1);
  end

endmodule
